// File: rtl/pe_array_feeder.sv
// Weight loader and diagonally-skewed activation streamer for a column of ROWS PEs.
// Lane r of every accepted activation vector reaches its PE r cycles after lane 0.
module pe_array_feeder #(
    parameter int ROWS               = 4,
    parameter int COMPUTE_DATA_WIDTH = 4,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [CNT_WIDTH-1:0]               num_vecs,
    input  logic                               w_valid,
    input  logic [ROWS*COMPUTE_DATA_WIDTH-1:0] w_data,
    output logic                               w_ready,
    input  logic                               a_valid,
    input  logic [ROWS*COMPUTE_DATA_WIDTH-1:0] a_data,
    output logic                               a_ready,
    output logic [ROWS*COMPUTE_DATA_WIDTH-1:0] pe_in,
    output logic [ROWS-1:0]                    pe_load_en,
    output logic [ROWS-1:0]                    pe_compute,
    output logic                               busy,
    output logic                               done
);

    localparam int W  = COMPUTE_DATA_WIDTH;
    localparam int DW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((ROWS > 1) ? ROWS - 2 : 0);

    typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DRAIN} state_t;

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic [DW-1:0]        drain_cnt, drain_next;
    logic                 done_next;
    logic                 w_hs, a_hs;
    logic                 load_q;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    assign w_hs       = w_valid & w_ready;
    assign a_hs       = a_valid & a_ready;
    assign busy       = (state != IDLE);
    assign pe_load_en = {ROWS{load_q}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            drain_cnt <= drain_next;
            done      <= done_next;
            load_q    <= w_hs;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        drain_next = drain_cnt;
        done_next  = 1'b0;
        w_ready    = 1'b0;
        a_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_vecs != '0) begin
                        cnt_next   = num_vecs;
                        state_next = WLOAD;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            WLOAD: begin
                w_ready = 1'b1;
                if (w_valid) state_next = STREAM;
            end
            STREAM: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        drain_next = '0;
                        if (ROWS > 1) begin
                            state_next = DRAIN;
                        end else begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                // done coincides with the final beat leaving the deepest lane.
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    drain_next = drain_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [W-1:0] lane_a, lane_w, src_d, pin_q;
        logic         src_c, comp_q;

        assign lane_a = a_data[r*W +: W];
        assign lane_w = w_data[r*W +: W];

        if (r == 0) begin : g_direct
            assign src_d = a_hs ? lane_a : '0;
            assign src_c = a_hs;
        end else begin : g_skew
            logic [W-1:0] dl [r];
            logic [r-1:0] cl;

            // Bubbles enter as zero data with compute low, so idle lanes stay at 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) dl[k] <= '0;
                    cl <= '0;
                end else begin
                    dl[0] <= a_hs ? lane_a : '0;
                    cl[0] <= a_hs;
                    for (int k = 1; k < r; k++) begin
                        dl[k] <= dl[k-1];
                        cl[k] <= cl[k-1];
                    end
                end
            end

            assign src_d = dl[r-1];
            assign src_c = cl[r-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pin_q  <= '0;
                comp_q <= 1'b0;
            end else begin
                pin_q  <= w_hs ? lane_w : src_d;
                comp_q <= src_c;
            end
        end

        assign pe_in[r*W +: W] = pin_q;
        assign pe_compute[r]   = comp_q;
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Self-checking bench for pe_array_feeder: job table, reset-abort sequence and random jobs,
// with per-lane expected-beat queues checked by a negedge monitor.
module tb_pe_array_feeder;

    localparam int ROWS = 4;
    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int DWID = ROWS * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, w_valid, a_valid;
    logic [CW-1:0]   num_vecs;
    logic [DWID-1:0] w_data, a_data, pe_in;
    logic            w_ready, a_ready, busy, done;
    logic [ROWS-1:0] pe_load_en, pe_compute;

    pe_array_feeder #(.ROWS(ROWS), .COMPUTE_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .pe_in(pe_in), .pe_load_en(pe_load_en), .pe_compute(pe_compute),
        .busy(busy), .done(done)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: lane beats {cycle, data}, weight loads {cycle, data}, done cycles
    logic [19:0] exp_q [ROWS][$];
    logic [31:0] w_q[$];
    int          done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    logic [31:0] mon_w;
    logic [19:0] mon_l;
    int          mon_d;

    always @(negedge clk) begin
        if (!rst) begin
            check("load_compute_exclusive", {31'd0, (|pe_load_en) & (|pe_compute)}, 32'd0);
            if (|pe_load_en) begin
                if (w_q.size() == 0) begin
                    check("unexpected_load", {28'd0, pe_load_en}, 32'd0);
                end else begin
                    mon_w = w_q.pop_front();
                    check("load_en_all", {28'd0, pe_load_en}, 32'hF);
                    check("load_cycle", {16'd0, cyc[15:0]}, {16'd0, mon_w[31:16]});
                    check("load_data", {16'd0, pe_in}, {16'd0, mon_w[15:0]});
                end
            end else if (w_q.size() != 0 && w_q[0][31:16] == cyc[15:0]) begin
                check("missing_load", {28'd0, pe_load_en}, 32'hF);
            end
            for (int r = 0; r < ROWS; r++) begin
                if (pe_compute[r]) begin
                    if (exp_q[r].size() == 0) begin
                        check("unexpected_compute", {31'd0, pe_compute[r]}, 32'd0);
                    end else begin
                        mon_l = exp_q[r].pop_front();
                        check("lane_cycle", {16'd0, cyc[15:0]}, {16'd0, mon_l[19:4]});
                        check("lane_data", {28'd0, pe_in[r*W +: W]}, {28'd0, mon_l[3:0]});
                    end
                end else begin
                    if (exp_q[r].size() != 0 && exp_q[r][0][19:4] == cyc[15:0])
                        check("missing_compute", {31'd0, pe_compute[r]}, 32'd1);
                    if (!pe_load_en[r])
                        check("idle_lane_zero", {28'd0, pe_in[r*W +: W]}, 32'd0);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d);
                end
            end else if (done_q.size() != 0 && done_q[0] == cyc) begin
                check("missing_done", {31'd0, done}, 32'd1);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          n;
        logic [15:0] w;
        logic [15:0] a_base;
        logic [15:0] a_step;
        int          gap;
        int          stall;
        bit          poke_start;
        int          exp_lat;
    } job_t;

    task automatic run_job(input job_t j);
        int          first;
        int          waited;
        logic [15:0] a;
        first = cyc;
        start    = 1'b1;
        num_vecs = j.n[CW-1:0];
        if (j.n == 0) done_q.push_back(cyc + 1);
        step();
        start    = 1'b0;
        num_vecs = '0;
        if (j.n == 0) begin
            check("zero_done", {31'd0, done}, 32'd1);
            check("zero_busy", {31'd0, busy}, 32'd0);
            check("zero_w_ready", {31'd0, w_ready}, 32'd0);
            step();
            check("zero_busy_after", {31'd0, busy}, 32'd0);
            check("zero_w_ready_after", {31'd0, w_ready}, 32'd0);
            check("zero_done_pulse", {31'd0, done}, 32'd0);
            return;
        end
        check("wload_busy", {31'd0, busy}, 32'd1);
        repeat (j.stall) begin
            check("stall_w_ready", {31'd0, w_ready}, 32'd1);
            step();
        end
        w_valid = 1'b1;
        w_data  = j.w;
        check("w_ready", {31'd0, w_ready}, 32'd1);
        w_q.push_back({16'(cyc + 1), j.w});
        step();
        w_valid = 1'b0;
        w_data  = '0;
        check("stream_w_ready_low", {31'd0, w_ready}, 32'd0);
        a = j.a_base;
        for (int k = 0; k < j.n; k++) begin
            if (k > 0) repeat (j.gap) step();
            a_valid = 1'b1;
            a_data  = a;
            if (j.poke_start && k == 0) begin
                start    = 1'b1;
                num_vecs = 8'd5;
            end
            check("a_ready", {31'd0, a_ready}, 32'd1);
            if (k == 0) first = cyc;
            for (int r = 0; r < ROWS; r++)
                exp_q[r].push_back({16'(cyc + 1 + r), a[r*W +: W]});
            if (k == j.n - 1) done_q.push_back(cyc + ROWS);
            step();
            a_valid  = 1'b0;
            a_data   = '0;
            start    = 1'b0;
            num_vecs = '0;
            a        = a + j.a_step;
        end
        check("drain_a_ready_low", {31'd0, a_ready}, 32'd0);
        waited = 0;
        while (!done && waited < 20) begin
            step();
            waited++;
        end
        check("done_latency", cyc - first, j.exp_lat);
        step();
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    job_t jobs[6];
    job_t rj;

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_vecs = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;

        jobs[0] = '{2, 16'h4321, 16'h8765, 16'h4444, 0, 0, 1'b0, 5};   // basic
        jobs[1] = '{2, 16'h1234, 16'h1111, 16'h2222, 2, 0, 1'b0, 7};   // bubbles
        jobs[2] = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 0};   // empty job
        jobs[3] = '{3, 16'hF0F0, 16'h1357, 16'h1111, 0, 5, 1'b1, 6};   // stall + ignored start
        jobs[4] = '{1, 16'hFFFF, 16'hABCD, 16'h0000, 1, 0, 1'b0, 4};
        jobs[5] = '{4, 16'h0F0F, 16'h0123, 16'h1010, 1, 2, 1'b0, 10};

        #2;
        check("rst_pe_in", {16'd0, pe_in}, 32'd0);
        check("rst_outputs", {24'd0, pe_load_en, pe_compute}, 32'd0);
        check("rst_flags", {28'd0, busy, done, w_ready, a_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        // Reset in the middle of streaming
        start = 1'b1; num_vecs = 8'd3;
        step();
        start = 1'b0; num_vecs = '0;
        w_valid = 1'b1; w_data = 16'h5A5A;
        w_q.push_back({16'(cyc + 1), 16'h5A5A});
        step();
        w_valid = 1'b0; w_data = '0;
        a_valid = 1'b1; a_data = 16'h2468;
        for (int r = 0; r < ROWS; r++)
            exp_q[r].push_back({16'(cyc + 1 + r), a_data[r*W +: W]});
        step();
        a_valid = 1'b0; a_data = '0;
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        for (int r = 0; r < ROWS; r++) exp_q[r].delete();
        w_q.delete();
        done_q.delete();
        #1;
        check("abort_pe_in", {16'd0, pe_in}, 32'd0);
        check("abort_strobes", {24'd0, pe_load_en, pe_compute}, 32'd0);
        check("abort_flags", {28'd0, busy, done, w_ready, a_ready}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (8) begin
            step();
            check("post_abort_idle", {30'd0, busy, done}, 32'd0);
        end
        rj = '{1, 16'h9876, 16'h5432, 16'h0000, 0, 0, 1'b0, 4};
        run_job(rj);

        // Random jobs
        for (int i = 0; i < 4; i++) begin
            rj.n          = $urandom_range(1, 4);
            rj.w          = 16'($urandom);
            rj.a_base     = 16'($urandom);
            rj.a_step     = 16'($urandom);
            rj.gap        = $urandom_range(0, 2);
            rj.stall      = $urandom_range(0, 3);
            rj.poke_start = 1'b0;
            rj.exp_lat    = (rj.n - 1) * (1 + rj.gap) + ROWS;
            run_job(rj);
        end

        repeat (4) step();
        check("queues_drained",
              w_q.size() + done_q.size() + exp_q[0].size() + exp_q[1].size()
              + exp_q[2].size() + exp_q[3].size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Upstream sequencer for a column of ROWS processing elements (PEs).
- Loads one weight per row in parallel, then streams activation vectors into the rows.
- Lane r of each activation vector is delayed r cycles, giving the diagonal skew the systolic array needs.
- Drives each PE's in, load_en and compute inputs, and signals completion once the last skewed beat has been issued.

Parameters:
- ROWS, 4, number of PE rows/lanes driven.
- COMPUTE_DATA_WIDTH, 4, width of one weight or activation lane.
- CNT_WIDTH, 8, width of the vector-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- num_vecs  in  CNT_WIDTH  number of activation vectors in the job; sampled with start.
- w_valid  in  1  weight vector valid.
- w_data  in  ROWS*COMPUTE_DATA_WIDTH  weights; lane r = bits [r*W +: W].
- w_ready  out  1  weight accept; high only in WLOAD.
- a_valid  in  1  activation vector valid.
- a_data  in  ROWS*COMPUTE_DATA_WIDTH  activations, same lane packing as w_data.
- a_ready  out  1  activation accept; high only in STREAM.
- pe_in  out  ROWS*COMPUTE_DATA_WIDTH  per-row PE data input.
- pe_load_en  out  ROWS  per-row weight-load strobe.
- pe_compute  out  ROWS  per-row compute enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, counters = 0, all skew registers = 0. All outputs read 0.
- Reset mid-job: aborts the job immediately. No done pulse is issued.
- All PE-side outputs are registered.
- State IDLE:
  - start with num_vecs != 0: latch num_vecs into the remaining-vector counter, go to WLOAD.
  - start with num_vecs == 0: done = 1 on the next cycle, remain in IDLE.
  - start while busy is ignored.
- State WLOAD:
  - w_ready = 1.
  - On w_valid & w_ready at cycle t: at t+1, pe_load_en = all ones, pe_in = w_data (no skew), pe_compute = 0. Go to STREAM.
- State STREAM:
  - a_ready = 1.
  - Each handshake (a_valid & a_ready) at cycle t drives lane r with a_data lane r on pe_in and pe_compute[r] = 1 at cycle t+1+r.
  - A cycle without a handshake injects a bubble: that lane slot carries pe_in = 0, pe_compute = 0, delayed identically.
  - The remaining-vector counter decrements on each handshake.
  - The handshake that brings the counter to 0 moves the FSM to DRAIN.
- State DRAIN:
  - Lasts exactly ROWS-1 cycles; a_ready = 0. Zeros and bubbles shift through the skew lines.
  - With the last handshake at cycle t, done = 1 at cycle t+ROWS, the same cycle lane ROWS-1 presents the final beat. The FSM then returns to IDLE.
  - ROWS == 1: DRAIN is zero cycles; done = 1 at t+1.
- pe_load_en is never asserted in the same cycle as any pe_compute bit. WLOAD always precedes STREAM, and the skew lines are empty on entry to WLOAD.
- Outside load/compute beats, pe_in lanes are 0, so PE pass-through data is deterministic.
- Arithmetic: no arithmetic on data. The counter is unsigned CNT_WIDTH bits and never wraps, because 0 is handled in IDLE.
- Skew line for lane r: r registers after the common input stage; lane 0 has latency 1.

Test Plan:
- Reset mid-STREAM:
  - Stimulus: ROWS=4; start, num_vecs=3; then assert rst for 1 cycle asynchronously, between clock edges.
  - Required: all outputs 0 immediately, state IDLE, no done pulse.
  - Then: start, num_vecs=1 completes normally.
- Basic job:
  - Stimulus: ROWS=4; start, num_vecs=2; w_data lanes {1,2,3,4}; a_data {5,6,7,8} accepted at cycle t, then {9,A,B,C} at t+1.
  - Required: pe_load_en=4'hF with pe_in {1,2,3,4} one cycle after the weight handshake.
  - Required: lane r shows 5+r at t+1+r and 9+r at t+2+r, with matching pe_compute bits.
  - Required: done at t+1+4 = t+5, busy low the next cycle.
- Bubble:
  - Stimulus: num_vecs=2; a_valid low for 2 cycles between the two beats.
  - Required: each lane shows 2 bubble cycles (pe_compute=0, pe_in=0) between beats; done 4 cycles after the second handshake.
- num_vecs=0:
  - Stimulus: start with num_vecs=0.
  - Required: done=1 next cycle, busy stays 0, w_ready never asserted.
- Stall and ignored start:
  - Stimulus: in WLOAD hold w_valid=0 for 5 cycles; pulse start during STREAM.
  - Required: no PE strobes during the stall; the extra start has no effect; the single job completes with exactly one done pulse.
